// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcode values, instruction formats and
// the opcode-to-format classification used by the decoder.
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 21;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    // Map an opcode to its encoding format; anything unrecognised is FMT_X.
    function automatic fmt_e classify(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP_R:                                   fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    fmt = FMT_I;
            OP_STORE:                               fmt = FMT_S;
            OP_BRANCH:                              fmt = FMT_B;
            OP_LUI, OP_AUIPC:                       fmt = FMT_U;
            OP_JAL:                                 fmt = FMT_J;
            default:                                fmt = FMT_X;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate generator: assembles the sign-extended 21-bit
// immediate for the given format and flags the wide (U/J) forms.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7]      instr_i,
    input  fmt_e             fmt_i,
    output logic [IMM_W-1:0] imm_o,
    output logic             size_o
);

    // Select the immediate bit layout for the decoded format.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        imm_o  = '0;
        size_o = 1'b0;
        case (fmt_i)
            FMT_I: imm_o = {{9{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm_o = {{9{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm_o = {{8{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_J: begin
                imm_o  = {instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
                size_o = 1'b1;
            end
            FMT_U: begin
                // Upper value kept unshifted; only the sign bit is replicated.
                imm_o  = {instr_i[31], instr_i[31:12]};
                size_o = 1'b1;
            end
            default: begin
                imm_o  = '0;
                size_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_instr_decoder.sv
// Registered RV32I field decoder: classifies the instruction format, masks
// fields the format does not define, and registers everything one cycle.
module rv32i_instr_decoder
    import rv32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  instruction,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [6:0]       opcode,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [IMM_W-1:0] imm,
    output logic             size
);

    fmt_e             fmt;
    logic [2:0]       func3_d, func3_q;
    logic [6:0]       func7_d, func7_q;
    logic [6:0]       opcode_d, opcode_q;
    logic [4:0]       rs1_d, rs1_q;
    logic [4:0]       rs2_d, rs2_q;
    logic [4:0]       rd_d, rd_q;
    logic [IMM_W-1:0] imm_d, imm_q;
    logic             size_d, size_q;

    assign fmt = classify(instruction[6:0]);

    rv32_imm_gen u_imm_gen (
        .instr_i (instruction[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm_d),
        .size_o  (size_d)
    );

    // Pass through the register/function fields the current format defines.
    always_comb begin
        opcode_d = instruction[6:0];
        func3_d  = '0;
        func7_d  = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        case (fmt)
            FMT_R: begin
                func3_d = instruction[14:12];
                func7_d = instruction[31:25];
                rs1_d   = instruction[19:15];
                rs2_d   = instruction[24:20];
                rd_d    = instruction[11:7];
            end
            FMT_I: begin
                func3_d = instruction[14:12];
                rs1_d   = instruction[19:15];
                rd_d    = instruction[11:7];
            end
            FMT_S, FMT_B: begin
                func3_d = instruction[14:12];
                rs1_d   = instruction[19:15];
                rs2_d   = instruction[24:20];
            end
            FMT_U, FMT_J: begin
                rd_d    = instruction[11:7];
            end
            default: begin
                func3_d = '0;
            end
        endcase
    end

    // Output registers with synchronous reset taking priority over decode.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            func3_q  <= '0;
            func7_q  <= '0;
            opcode_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            size_q   <= 1'b0;
        end else begin
            func3_q  <= func3_d;
            func7_q  <= func7_d;
            opcode_q <= opcode_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            size_q   <= size_d;
        end
    end

    assign func3  = func3_q;
    assign func7  = func7_q;
    assign opcode = opcode_q;
    assign rs1    = rs1_q;
    assign rs2    = rs2_q;
    assign rd     = rd_q;
    assign imm    = imm_q;
    assign size   = size_q;

endmodule

// File: tb/tb_rv32i_instr_decoder.sv
// Self-checking bench for rv32i_instr_decoder: directed encodings with
// hand-derived results, then a random stream against an arithmetic model.
module tb_rv32i_instr_decoder;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [20:0] imm;
        logic        size;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [20:0] imm;
    logic        size;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_instr_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .func3       (func3),
        .func7       (func7),
        .opcode      (opcode),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .size        (size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input dec_t e);
        check({tag, ".opcode"}, 32'(opcode), 32'(e.opcode));
        check({tag, ".func3"},  32'(func3),  32'(e.f3));
        check({tag, ".func7"},  32'(func7),  32'(e.f7));
        check({tag, ".rs1"},    32'(rs1),    32'(e.rs1));
        check({tag, ".rs2"},    32'(rs2),    32'(e.rs2));
        check({tag, ".rd"},     32'(rd),     32'(e.rd));
        check({tag, ".imm"},    32'(imm),    32'(e.imm));
        check({tag, ".size"},   32'(size),   32'(e.size));
    endtask

    // Reference decode: format from the opcode table, immediates as signed
    // integer sums of their weighted bit groups.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   v;
        byte  k;
        d = '0;
        v = 0;
        d.opcode = w[6:0];
        case (w[6:0])
            7'b0110011:                                     k = "R";
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: k = "I";
            7'b0100011:                                     k = "S";
            7'b1100011:                                     k = "B";
            7'b0110111, 7'b0010111:                         k = "U";
            7'b1101111:                                     k = "J";
            default:                                        k = "X";
        endcase
        if (k inside {"R", "I", "S", "B"}) begin
            d.f3  = w[14:12];
            d.rs1 = w[19:15];
        end
        if (k inside {"R", "S", "B"}) d.rs2 = w[24:20];
        if (k inside {"R", "I", "U", "J"}) d.rd = w[11:7];
        if (k == "R") d.f7 = w[31:25];
        case (k)
            "I": v = int'(w[30:20]) - (w[31] ? 2048 : 0);
            "S": v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
            "B": v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                     - (w[31] ? 4096 : 0);
            "J": v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                     - (w[31] ? 1048576 : 0);
            "U": v = int'(w[30:12]) - (w[31] ? 524288 : 0);
            default: v = 0;
        endcase
        d.imm  = v[20:0];
        d.size = (k == "U" || k == "J");
        return d;
    endfunction

    // Present one instruction, let one edge pass, compare the registered result.
    task automatic apply(input string tag, input logic [31:0] w, input dec_t e);
        instruction = w;
        @(posedge clk);
        #1;
        check_all(tag, e);
    endtask

    logic [6:0] op_tbl [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b0000000};

    initial begin
        dec_t zero;
        zero = '0;

        // Reset held for two edges with a decodable instruction present.
        rst = 1'b1;
        instruction = 32'h002080B3;
        @(posedge clk); #1;
        check_all("rst0", zero);
        @(posedge clk); #1;
        check_all("rst1", zero);
        rst = 1'b0;

        // Directed encodings, back to back on consecutive edges.
        apply("add",   32'h002080B3, '{7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd1, 21'h000000, 1'b0});
        apply("beq",   32'h002080E3, '{7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 21'h000800, 1'b0});
        apply("jal",   32'h000800EF, '{7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 21'h080000, 1'b1});
        apply("sw",    32'h0020A423, '{7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 21'h000008, 1'b0});
        apply("addi",  32'hFFF00093, '{7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 21'h1FFFFF, 1'b0});
        apply("lui",   32'h800002B7, '{7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 21'h180000, 1'b1});
        apply("sub",   32'h40B50533, '{7'h33, 3'd0, 7'h20, 5'd10, 5'd11, 5'd10, 21'h0, 1'b0});
        apply("unk0",  32'hFFFFFF80, zero);
        apply("unk1",  32'hFFFFFFFF, '{7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h0, 1'b0});

        // Reset mid-stream clears, then decoding resumes on the following edge.
        rst = 1'b1;
        apply("rst_mid", 32'hFFF00093, zero);
        rst = 1'b0;
        apply("resume", 32'h000800EF, '{7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 21'h080000, 1'b1});

        // Random stream with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) != 0)
                w[6:0] = op_tbl[$urandom_range(0, 10)];
            rst = ($urandom_range(0, 19) == 0);
            apply("rnd", w, rst ? zero : ref_decode(w));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
